// File: rtl/fabric_cfg_loader.sv
// ---------------------------------------------------------------------------
// fabric_cfg_loader
//
// Serial configuration loader for the 6-IOB / 1-CLB fabric. A one-bit
// configuration stream is searched for an 8-bit sync pattern. The 75-bit
// frame that follows is shifted into a shadow register, then one parity bit
// is taken. The frame is checked for parity, select range and input
// contention. Only a clean frame is copied, in a single cycle, onto the select
// bus that drives the fabric. A bad frame leaves the live bus untouched.
//
// Ports
//   i_clk            fabric clock, rising edge
//   i_rst            asynchronous active-high reset
//   i_cfg_din        serial configuration bit
//   i_cfg_valid      qualifies i_cfg_din, one bit accepted per valid cycle
//   i_cfg_abort      synchronous abort of a frame in progress
//   o_cfg_bus[74:0]  live select bus, MSB first
//                      IOB n (1..6): [74-9(n-1) -: 9] = ts, out, in (3b each)
//                      CLB: A[20:18] B[17:15] C[14:12] D[11:9] K[8:6]
//                           X[5:3] Y[2:0]
//   o_cfg_busy       high while a frame is being loaded or checked
//   o_cfg_load       one-cycle pulse when o_cfg_bus takes a new frame
//   o_cfg_done       set by the first successful commit, held until reset
//   o_cfg_err        sticky error, cleared by the next sync detect
//   o_cfg_err_code   01 parity, 10 illegal field, 11 abort, 00 no error
// ---------------------------------------------------------------------------
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_HUNT   | shifting valid bits through the sync shifter, looking for SYNC
// ST_LOAD   | shifting the 75 payload bits into the shadow register
// ST_PARITY | waiting for the single parity bit
// ST_CHECK  | one cycle: judge parity and fields, commit or flag error
//
module fabric_cfg_loader #(
   parameter  logic [7:0] SYNC    = 8'hA5,
   localparam int         FRAME_W = 75
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_cfg_din,
   input  logic               i_cfg_valid,
   input  logic               i_cfg_abort,
   output logic [FRAME_W-1:0] o_cfg_bus,
   output logic               o_cfg_busy,
   output logic               o_cfg_load,
   output logic               o_cfg_done,
   output logic               o_cfg_err,
   output logic [1:0]         o_cfg_err_code
);

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_PARITY = 2'd2,
      ST_CHECK  = 2'd3
   } state_t;

   localparam logic [1:0] ERR_NONE   = 2'b00;
   localparam logic [1:0] ERR_PARITY = 2'b01;
   localparam logic [1:0] ERR_FIELD  = 2'b10;
   localparam logic [1:0] ERR_ABORT  = 2'b11;

   // Row-indexed selects address 5 rows (values 0..4); column-indexed
   // selects address 6 columns (values 0..5). 0 always means undriven.
   localparam logic [2:0] ROW_MAX = 3'd4;
   localparam logic [2:0] COL_MAX = 3'd5;

   state_t               r_state;
   logic [7:0]           r_sync;
   logic [6:0]           r_cnt;
   logic [FRAME_W-1:0]   r_shadow;
   logic                 r_par;
   logic [FRAME_W-1:0]   r_bus;
   logic                 r_busy;
   logic                 r_load;
   logic                 r_done;
   logic                 r_err;
   logic [1:0]           r_err_code;

   logic [7:0]           w_sync_next;
   logic                 w_sync_hit;

   logic [2:0]           w_ts  [6];
   logic [2:0]           w_out [6];
   logic [2:0]           w_in  [6];
   logic [2:0]           w_a, w_b, w_c, w_d, w_k, w_x, w_y;
   logic                 w_range_bad;
   logic                 w_cont_bad;
   logic                 w_field_bad;

   // -----------------------------------------------------------------------
   // Sync detection looks at the shifter including the bit being accepted,
   // so LOAD is entered on the same edge that takes the 8th sync bit.
   // -----------------------------------------------------------------------
   assign w_sync_next = {r_sync[6:0], i_cfg_din};
   assign w_sync_hit  = (w_sync_next == SYNC);

   // -----------------------------------------------------------------------
   // Field views of the shadow register
   // -----------------------------------------------------------------------
   for (genvar n = 0; n < 6; n++) begin : g_iob
      assign w_ts[n]  = r_shadow[74 - 9*n -: 3];
      assign w_out[n] = r_shadow[71 - 9*n -: 3];
      assign w_in[n]  = r_shadow[68 - 9*n -: 3];
   end

   assign w_a = r_shadow[20:18];
   assign w_b = r_shadow[17:15];
   assign w_c = r_shadow[14:12];
   assign w_d = r_shadow[11:9];
   assign w_k = r_shadow[8:6];
   assign w_x = r_shadow[5:3];
   assign w_y = r_shadow[2:0];

   // IOB index 2 and 5 (io3, io6) sit on columns; the rest sit on rows.
   always_comb begin
      w_range_bad = 1'b0;
      for (int n = 0; n < 6; n++) begin
         if ((n == 2) || (n == 5)) begin
            if ((w_ts[n] > COL_MAX) || (w_out[n] > COL_MAX) || (w_in[n] > COL_MAX))
               w_range_bad = 1'b1;
         end else begin
            if ((w_ts[n] > ROW_MAX) || (w_out[n] > ROW_MAX) || (w_in[n] > ROW_MAX))
               w_range_bad = 1'b1;
         end
      end
      if ((w_a > ROW_MAX) || (w_d > ROW_MAX))
         w_range_bad = 1'b1;
      if ((w_b > COL_MAX) || (w_c > COL_MAX) || (w_k > COL_MAX) ||
          (w_x > COL_MAX) || (w_y > COL_MAX))
         w_range_bad = 1'b1;
   end

   // Two sources driving the same fabric node: io1/io2 inputs share rows,
   // io4/io5 inputs share rows, and io3 input, X and Y share columns.
   always_comb begin
      w_cont_bad = 1'b0;
      if ((w_in[0] != 3'd0) && (w_in[0] == w_in[1]))
         w_cont_bad = 1'b1;
      if ((w_in[3] != 3'd0) && (w_in[3] == w_in[4]))
         w_cont_bad = 1'b1;
      if ((w_in[2] != 3'd0) && (w_in[2] == w_x))
         w_cont_bad = 1'b1;
      if ((w_in[2] != 3'd0) && (w_in[2] == w_y))
         w_cont_bad = 1'b1;
      if ((w_x != 3'd0) && (w_x == w_y))
         w_cont_bad = 1'b1;
   end

   assign w_field_bad = w_range_bad | w_cont_bad;

   // -----------------------------------------------------------------------
   // Sequencer. r_par accumulates the XOR of every payload and parity bit,
   // so it is 0 in CHECK exactly when even parity holds.
   // -----------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= ST_HUNT;
         r_sync     <= 8'd0;
         r_cnt      <= 7'd0;
         r_shadow   <= '0;
         r_par      <= 1'b0;
         r_bus      <= '0;
         r_busy     <= 1'b0;
         r_load     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= ERR_NONE;
      end else begin
         r_load <= 1'b0;
         case (r_state)
            ST_HUNT: begin
               if (i_cfg_valid) begin
                  r_sync <= w_sync_next;
                  if (w_sync_hit) begin
                     r_state    <= ST_LOAD;
                     r_cnt      <= 7'd0;
                     r_par      <= 1'b0;
                     r_busy     <= 1'b1;
                     r_err      <= 1'b0;
                     r_err_code <= ERR_NONE;
                  end
               end
            end

            ST_LOAD: begin
               if (i_cfg_abort) begin
                  r_state    <= ST_HUNT;
                  r_sync     <= 8'd0;
                  r_busy     <= 1'b0;
                  r_err      <= 1'b1;
                  r_err_code <= ERR_ABORT;
               end else if (i_cfg_valid) begin
                  r_shadow <= {r_shadow[FRAME_W-2:0], i_cfg_din};
                  r_par    <= r_par ^ i_cfg_din;
                  r_cnt    <= r_cnt + 7'd1;
                  if (r_cnt == 7'(FRAME_W - 1))
                     r_state <= ST_PARITY;
               end
            end

            ST_PARITY: begin
               if (i_cfg_abort) begin
                  r_state    <= ST_HUNT;
                  r_sync     <= 8'd0;
                  r_busy     <= 1'b0;
                  r_err      <= 1'b1;
                  r_err_code <= ERR_ABORT;
               end else if (i_cfg_valid) begin
                  r_par   <= r_par ^ i_cfg_din;
                  r_state <= ST_CHECK;
               end
            end

            ST_CHECK: begin
               // Any bit offered in this cycle is dropped on purpose.
               r_state <= ST_HUNT;
               r_sync  <= 8'd0;
               r_busy  <= 1'b0;
               if (r_par) begin
                  r_err      <= 1'b1;
                  r_err_code <= ERR_PARITY;
               end else if (w_field_bad) begin
                  r_err      <= 1'b1;
                  r_err_code <= ERR_FIELD;
               end else begin
                  r_bus  <= r_shadow;
                  r_load <= 1'b1;
                  r_done <= 1'b1;
               end
            end

            default: begin
               r_state <= ST_HUNT;
               r_sync  <= 8'd0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_cfg_bus      = r_bus;
   assign o_cfg_busy     = r_busy;
   assign o_cfg_load     = r_load;
   assign o_cfg_done     = r_done;
   assign o_cfg_err      = r_err;
   assign o_cfg_err_code = r_err_code;

endmodule

// File: tb/tb_fabric_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_fabric_cfg_loader
//
// Frames are taken from a table of {frame, parity flip, gap mode, expected
// error code}. Each frame's expected outcome is queued when its parity bit is
// driven. A monitor pops and compares it when the loader leaves busy.
// Hand sequences cover abort, asynchronous reset and reload after reset.
// ---------------------------------------------------------------------------
module tb_fabric_cfg_loader;

   logic        i_clk;
   logic        i_rst;
   logic        i_cfg_din;
   logic        i_cfg_valid;
   logic        i_cfg_abort;
   logic [74:0] o_cfg_bus;
   logic        o_cfg_busy;
   logic        o_cfg_load;
   logic        o_cfg_done;
   logic        o_cfg_err;
   logic [1:0]  o_cfg_err_code;

   fabric_cfg_loader dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_cfg_din      (i_cfg_din),
      .i_cfg_valid    (i_cfg_valid),
      .i_cfg_abort    (i_cfg_abort),
      .o_cfg_bus      (o_cfg_bus),
      .o_cfg_busy     (o_cfg_busy),
      .o_cfg_load     (o_cfg_load),
      .o_cfg_done     (o_cfg_done),
      .o_cfg_err      (o_cfg_err),
      .o_cfg_err_code (o_cfg_err_code)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [74:0] frame;
      logic        flip;
      logic        gaps;
      logic [1:0]  exp_code;
   } vec_t;

   typedef struct {
      logic [74:0] bus;
      logic [1:0]  code;
      logic        commit;
      logic        done;
   } exp_t;

   exp_t        sb_q[$];
   int          checks     = 0;
   int          failures   = 0;
   int          load_seen  = 0;
   int          commits    = 0;
   logic [74:0] model_bus  = '0;
   logic        model_done = 1'b0;
   logic        prev_busy  = 1'b0;
   logic [7:0]  sync_v     = 8'hA5;

   task automatic chk(input string name, input logic [74:0] act, input logic [74:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [74:0] put_iob(input logic [74:0] f, input int n,
                                          input logic [2:0] ts, input logic [2:0] out,
                                          input logic [2:0] inn);
      logic [74:0] r;
      r = f;
      r[74 - 9*(n-1) -: 3] = ts;
      r[71 - 9*(n-1) -: 3] = out;
      r[68 - 9*(n-1) -: 3] = inn;
      return r;
   endfunction

   function automatic logic [74:0] put_clb(input logic [74:0] f,
                                          input logic [2:0] a, input logic [2:0] b,
                                          input logic [2:0] c, input logic [2:0] d,
                                          input logic [2:0] k, input logic [2:0] x,
                                          input logic [2:0] y);
      logic [74:0] r;
      r = f;
      r[20:0] = {a, b, c, d, k, x, y};
      return r;
   endfunction

   // Monitor: a busy -> idle transition is the end of a frame or an abort.
   always @(negedge i_clk) begin
      if (i_rst) begin
         prev_busy = 1'b0;
      end else begin
         if (o_cfg_load) load_seen++;
         if (prev_busy && !o_cfg_busy) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_end actual=busy_fell expected=no_event");
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("end_bus",  o_cfg_bus, e.bus);
               chk("end_code", 75'(o_cfg_err_code), 75'(e.code));
               chk("end_err",  75'(o_cfg_err), 75'(e.code != 2'b00));
               chk("end_load", 75'(o_cfg_load), 75'(e.commit));
               chk("end_done", 75'(o_cfg_done), 75'(e.done));
            end
         end
         prev_busy = o_cfg_busy;
      end
   end

   task automatic send_bit(input logic b, input logic gaps);
      if (gaps) begin
         int g;
         g = 0;
         while (($urandom_range(0, 1) == 1) && (g < 6)) begin
            i_cfg_valid = 1'b0;
            i_cfg_din   = $urandom_range(0, 1) == 1;
            @(negedge i_clk);
            g++;
         end
      end
      i_cfg_din   = b;
      i_cfg_valid = 1'b1;
      @(negedge i_clk);
      i_cfg_valid = 1'b0;
   endtask

   task automatic send_sync(input logic gaps);
      for (int i = 7; i >= 0; i--) send_bit(sync_v[i], gaps);
      chk("sync_busy",  75'(o_cfg_busy), 75'(1'b1));
      chk("sync_err",   75'(o_cfg_err), 75'(1'b0));
      chk("sync_code",  75'(o_cfg_err_code), 75'(2'b00));
   endtask

   task automatic send_payload(input logic [74:0] f, input int nbits, input logic gaps);
      for (int i = 0; i < nbits; i++) send_bit(f[74 - i], gaps);
   endtask

   task automatic send_frame(input logic [74:0] f, input logic flip, input logic gaps,
                             input logic [1:0] code);
      exp_t e;
      send_sync(gaps);
      send_payload(f, 75, gaps);
      if (code == 2'b00) begin
         model_bus  = f;
         model_done = 1'b1;
         commits++;
      end
      e.bus    = model_bus;
      e.code   = code;
      e.commit = (code == 2'b00);
      e.done   = model_done;
      sb_q.push_back(e);
      send_bit((^f) ^ flip, gaps);
      chk("check_busy", 75'(o_cfg_busy), 75'(1'b1));
      i_cfg_valid = 1'b0;
      @(negedge i_clk);
      chk("after_busy", 75'(o_cfg_busy), 75'(1'b0));
      @(negedge i_clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   logic [74:0] bring;
   logic [74:0] f_tmp;
   vec_t        vt[12];

   initial begin
      i_rst       = 1'b1;
      i_cfg_din   = 1'b0;
      i_cfg_valid = 1'b0;
      i_cfg_abort = 1'b0;

      bring = '0;
      bring = put_iob(bring, 1, 3'd0, 3'd0, 3'd2);
      bring = put_iob(bring, 2, 3'd0, 3'd0, 3'd1);
      bring = put_iob(bring, 3, 3'd0, 3'd3, 3'd0);
      bring = put_iob(bring, 4, 3'd0, 3'd0, 3'd2);
      bring = put_iob(bring, 5, 3'd0, 3'd0, 3'd4);
      bring = put_iob(bring, 6, 3'd0, 3'd0, 3'd4);
      bring = put_clb(bring, 3'd1, 3'd5, 3'd4, 3'd2, 3'd3, 3'd3, 3'd0);

      vt[0]  = '{bring, 1'b1, 1'b0, 2'b01};
      vt[1]  = '{bring, 1'b0, 1'b0, 2'b00};
      vt[2]  = '{put_clb(bring, 3'd5, 3'd5, 3'd4, 3'd2, 3'd3, 3'd3, 3'd0), 1'b0, 1'b0, 2'b10};
      vt[3]  = '{put_iob(put_iob(bring, 1, 3'd0, 3'd0, 3'd3), 2, 3'd0, 3'd0, 3'd3),
                 1'b0, 1'b0, 2'b10};
      vt[4]  = '{put_clb(bring, 3'd1, 3'd5, 3'd4, 3'd2, 3'd3, 3'd2, 3'd2), 1'b0, 1'b0, 2'b10};
      f_tmp  = put_iob('0, 1, 3'd4, 3'd0, 3'd0);
      f_tmp  = put_iob(f_tmp, 3, 3'd5, 3'd0, 3'd0);
      f_tmp  = put_iob(f_tmp, 6, 3'd0, 3'd5, 3'd0);
      f_tmp  = put_clb(f_tmp, 3'd4, 3'd0, 3'd0, 3'd4, 3'd5, 3'd0, 3'd5);
      vt[5]  = '{f_tmp, 1'b0, 1'b0, 2'b00};
      vt[6]  = '{put_iob('0, 3, 3'd6, 3'd0, 3'd0), 1'b0, 1'b0, 2'b10};
      vt[7]  = '{put_iob('0, 2, 3'd0, 3'd5, 3'd0), 1'b0, 1'b0, 2'b10};
      vt[8]  = '{put_clb(put_iob('0, 3, 3'd0, 3'd0, 3'd3), 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
                         3'd3, 3'd0), 1'b0, 1'b0, 2'b10};
      vt[9]  = '{vt[2].frame, 1'b1, 1'b0, 2'b01};
      // B,C,D = 101 001 010 puts 8'hA5 inside the payload stream.
      vt[10] = '{put_clb(bring, 3'd1, 3'd5, 3'd1, 3'd2, 3'd3, 3'd3, 3'd0), 1'b0, 1'b1, 2'b00};
      vt[11] = '{put_iob(put_iob('0, 4, 3'd0, 3'd0, 3'd1), 5, 3'd0, 3'd0, 3'd1),
                 1'b0, 1'b0, 2'b10};

      #3;
      chk("rst_bus",  o_cfg_bus, 75'(0));
      chk("rst_flags", 75'({o_cfg_busy, o_cfg_load, o_cfg_done, o_cfg_err, o_cfg_err_code}),
          75'(0));
      @(negedge i_clk);
      #3 i_rst = 1'b0;
      @(negedge i_clk);
      chk("post_rst_bus", o_cfg_bus, 75'(0));
      chk("post_rst_flags",
          75'({o_cfg_busy, o_cfg_load, o_cfg_done, o_cfg_err, o_cfg_err_code}), 75'(0));

      for (int i = 0; i < 12; i++) begin
         send_frame(vt[i].frame, vt[i].flip, vt[i].gaps, vt[i].exp_code);
         if (i == 1) begin
            chk("in1",  75'(o_cfg_bus[68:66]), 75'(3'd2));
            chk("in2",  75'(o_cfg_bus[59:57]), 75'(3'd1));
            chk("out3", 75'(o_cfg_bus[53:51]), 75'(3'd3));
            chk("in6",  75'(o_cfg_bus[23:21]), 75'(3'd4));
            chk("clb",  75'(o_cfg_bus[20:0]),
                75'({3'd1, 3'd5, 3'd4, 3'd2, 3'd3, 3'd3, 3'd0}));
         end
      end

      // Abort after 40 payload bits.
      begin
         exp_t e;
         send_sync(1'b0);
         send_payload(bring, 40, 1'b0);
         e.bus    = model_bus;
         e.code   = 2'b11;
         e.commit = 1'b0;
         e.done   = model_done;
         sb_q.push_back(e);
         i_cfg_abort = 1'b1;
         @(negedge i_clk);
         i_cfg_abort = 1'b0;
         chk("abort_busy", 75'(o_cfg_busy), 75'(1'b0));
         chk("abort_code", 75'(o_cfg_err_code), 75'(2'b11));
         // Abort in HUNT has no effect.
         i_cfg_abort = 1'b1;
         @(negedge i_clk);
         i_cfg_abort = 1'b0;
         @(negedge i_clk);
         chk("hunt_abort_code", 75'(o_cfg_err_code), 75'(2'b11));
         chk("hunt_abort_bus", o_cfg_bus, model_bus);
      end

      // Asynchronous reset in the middle of a frame.
      send_sync(1'b0);
      send_payload(bring, 30, 1'b0);
      #3 i_rst = 1'b1;
      #1;
      chk("async_rst_bus", o_cfg_bus, 75'(0));
      chk("async_rst_flags",
          75'({o_cfg_busy, o_cfg_load, o_cfg_done, o_cfg_err, o_cfg_err_code}), 75'(0));
      model_bus  = '0;
      model_done = 1'b0;
      @(negedge i_clk);
      #3 i_rst = 1'b0;
      @(negedge i_clk);
      send_frame(vt[5].frame, 1'b0, 1'b0, 2'b00);

      repeat (3) @(negedge i_clk);
      chk("pending_expectations", 75'(sb_q.size()), 75'(0));
      chk("load_pulses", 75'(load_seen), 75'(commits));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
